// File: rtl/fetch_pkg.sv
// Shared constants and next-PC source encoding for the fetch, decode and hazard blocks.
package fetch_pkg;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h0000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0008;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    HOLD   = 3'd1,
    JUMP   = 3'd2,
    JR     = 3'd3,
    BRANCH = 3'd4,
    IRQ    = 3'd5,
    EXC    = 3'd6
  } next_src_e;

  function automatic logic is_redirect(input next_src_e src);
    return !((src == SEQ) || (src == HOLD));
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority selector; also produces the return address saved on trap entry.
// The irq level exists only when FETCH_IRQ_EN is defined.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jr_en,
  input  logic [PC_W-1:0] jr_target,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_target,
  input  logic            irq,
  input  logic            exc,
  input  logic            kernel,
  output next_src_e       src,
  output logic [PC_W-1:0] next_pc,
  output logic [PC_W-1:0] epc_val
);

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_t;
  logic [PC_W-1:0] jr_t;
  logic [PC_W-1:0] jmp_t;
  logic [PC_W-1:0] lower_t;
  logic            irq_take;

  assign pc_plus4 = pc + PC_W'(4);
  assign br_t     = {branch_target[PC_W-1:2], 2'b00};
  assign jr_t     = {jr_target[PC_W-1:2], 2'b00};
  assign jmp_t    = {jump_target[PC_W-1:2], 2'b00};

`ifdef FETCH_IRQ_EN
  assign irq_take = irq & ~kernel & ~stall;
`else
  logic unused_irq;
  assign unused_irq = irq ^ kernel;
  assign irq_take   = 1'b0;
`endif

  // A trap returns to wherever this cycle would have gone without it.
  always_comb begin
    if (branch_en)    lower_t = br_t;
    else if (jr_en)   lower_t = jr_t;
    else if (jump_en) lower_t = jmp_t;
    else              lower_t = pc;
  end

  always_comb begin
    src     = SEQ;
    next_pc = pc_plus4;
    epc_val = lower_t;
    if (exc) begin
      src     = EXC;
      next_pc = PC_W'(EXC_VEC);
    end else if (irq_take) begin
      src     = IRQ;
      next_pc = PC_W'(IRQ_VEC);
    end else if (branch_en) begin
      src     = BRANCH;
      next_pc = br_t;
    end else if (jr_en) begin
      src     = JR;
      next_pc = jr_t;
    end else if (jump_en) begin
      src     = JUMP;
      next_pc = jmp_t;
    end else if (stall) begin
      src     = HOLD;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register, trap entry state (epc/kernel).
// Optional interrupt support is compiled in with FETCH_IRQ_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jr_en,
  input  logic [PC_W-1:0] jr_target,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_target,
  input  logic            irq,
  input  logic            exc,
  input  logic [31:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc_plus4,
  output logic            ifid_valid,
  output logic [PC_W-1:0] epc,
  output logic            kernel,
  output logic            redirect
);

  logic [PC_W-1:0] pc_q;
  logic [31:0]     ifid_instr_q;
  logic [PC_W-1:0] ifid_pc_plus4_q;
  logic            ifid_valid_q;
  logic [PC_W-1:0] epc_q;
  logic            redirect_q;
  logic            kernel_flag;

  next_src_e       src;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] epc_val;
  logic            trap_entry;

  pc_next_sel #(.PC_W(PC_W)) u_sel (
    .pc            (pc_q),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .irq           (irq),
    .exc           (exc),
    .kernel        (kernel_flag),
    .src           (src),
    .next_pc       (next_pc),
    .epc_val       (epc_val)
  );

  assign trap_entry = (src == EXC) || (src == IRQ);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q            <= PC_W'(RESET_VEC);
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      epc_q           <= '0;
      redirect_q      <= 1'b0;
    end else begin
      pc_q       <= next_pc;
      redirect_q <= is_redirect(src);
      // The instruction fetched this cycle is on the wrong path after any redirect.
      if (is_redirect(src)) begin
        ifid_instr_q    <= NOP_INSTR;
        ifid_pc_plus4_q <= '0;
        ifid_valid_q    <= 1'b0;
      end else if (src == SEQ) begin
        ifid_instr_q    <= instr;
        ifid_pc_plus4_q <= pc_q + PC_W'(4);
        ifid_valid_q    <= 1'b1;
      end
      if (trap_entry) begin
        epc_q <= epc_val;
      end
    end
  end

`ifdef FETCH_IRQ_EN
  logic kernel_q;

  // Boot starts in kernel mode; handlers and boot code leave it through jr.
  always_ff @(posedge clk) begin
    if (!reset) begin
      kernel_q <= 1'b1;
    end else if (trap_entry) begin
      kernel_q <= 1'b1;
    end else if (src == JR) begin
      kernel_q <= 1'b0;
    end
  end

  assign kernel_flag = kernel_q;
`else
  assign kernel_flag = 1'b0;
`endif

  assign pc            = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign epc           = epc_q;
  assign kernel        = kernel_flag;
  assign redirect      = redirect_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, then random requests against a reference model.
// Follows FETCH_IRQ_EN the same way as the design.
module tb_fetch_stage;

`ifdef FETCH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_en, jr_en, jump_en, irq, exc;
  logic [31:0] branch_target, jr_target, jump_target;
  logic [31:0] instr;
  logic [31:0] pc, ifid_instr, ifid_pc_plus4, epc;
  logic        ifid_valid, kernel, redirect;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [31:0] m_pc, m_ifid_instr, m_ifid_pc_plus4, m_epc;
  logic        m_ifid_valid, m_kernel, m_redirect;

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(32)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .irq           (irq),
    .exc           (exc),
    .instr         (instr),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .epc           (epc),
    .kernel        (kernel),
    .redirect      (redirect)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign instr = imem(pc);

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge of the fetch stage from the textual rules.
  task automatic model_edge();
    logic [31:0] br, jt, jm, fallthrough, old_pc;
    logic        irq_ok;
    if (!rst_n) begin
      m_pc = 0; m_ifid_instr = 0; m_ifid_pc_plus4 = 0; m_ifid_valid = 0;
      m_epc = 0; m_kernel = IRQ_EN; m_redirect = 0;
      return;
    end
    old_pc = m_pc;
    br = branch_target & 32'hFFFF_FFFC;
    jt = jr_target & 32'hFFFF_FFFC;
    jm = jump_target & 32'hFFFF_FFFC;
    fallthrough = branch_en ? br : jr_en ? jt : jump_en ? jm : old_pc;
    irq_ok = IRQ_EN && irq && !m_kernel && !stall;
    m_redirect = exc || irq_ok || branch_en || jr_en || jump_en;
    if (exc || irq_ok) begin
      m_pc = exc ? 32'h8 : 32'h4;
      m_epc = fallthrough;
      m_kernel = IRQ_EN;
    end else if (branch_en || jr_en || jump_en) begin
      m_pc = fallthrough;
      if (!branch_en && jr_en) m_kernel = 1'b0;
    end else if (!stall) begin
      m_ifid_instr = imem(old_pc);
      m_ifid_pc_plus4 = old_pc + 32'd4;
      m_ifid_valid = 1'b1;
      m_pc = old_pc + 32'd4;
    end
    if (m_redirect) begin
      m_ifid_instr = 0; m_ifid_pc_plus4 = 0; m_ifid_valid = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp("pc", pc, m_pc);
    cmp("ifid_instr", ifid_instr, m_ifid_instr);
    cmp("ifid_pc_plus4", ifid_pc_plus4, m_ifid_pc_plus4);
    cmp("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_ifid_valid});
    cmp("epc", epc, m_epc);
    cmp("kernel", {31'd0, kernel}, {31'd0, m_kernel});
    cmp("redirect", {31'd0, redirect}, {31'd0, m_redirect});
  endtask

  task automatic idle();
    stall = 0; branch_en = 0; jr_en = 0; jump_en = 0; exc = 0;
  endtask

  initial begin
    rst_n = 0; irq = 0; idle();
    branch_target = 0; jr_target = 0; jump_target = 0;
    m_pc = 0; m_ifid_instr = 0; m_ifid_pc_plus4 = 0; m_ifid_valid = 0;
    m_epc = 0; m_kernel = 0; m_redirect = 0;

    // Reset state
    step(); step();
    cmp("rst_pc", pc, 32'h0);
    cmp("rst_valid", {31'd0, ifid_valid}, 32'd0);
    cmp("rst_kernel", {31'd0, kernel}, {31'd0, IRQ_EN});

    // Sequential fetch after release
    rst_n = 1;
    step(); cmp("seq_pc4", pc, 32'h4); cmp("seq_pp4_a", ifid_pc_plus4, 32'h4);
    cmp("seq_valid", {31'd0, ifid_valid}, 32'd1);
    step(); cmp("seq_pc8", pc, 32'h8); cmp("seq_pp4_b", ifid_pc_plus4, 32'h8);
    step(); cmp("seq_pcC", pc, 32'hC);
    step(); cmp("seq_pc10", pc, 32'h10);

    // Stall holds everything
    stall = 1;
    step(); step(); cmp("stall_pc", pc, 32'h10); cmp("stall_pp4", ifid_pc_plus4, 32'h10);
    stall = 0;
    step(); cmp("unstall_pc", pc, 32'h14);

    // Branch beats jump and stall; target low bits cleared
    branch_en = 1; branch_target = 32'h123; jump_en = 1; jump_target = 32'h200; stall = 1;
    step(); cmp("br_pc", pc, 32'h120); cmp("br_valid", {31'd0, ifid_valid}, 32'd0);
    cmp("br_instr", ifid_instr, 32'h0); cmp("br_redirect", {31'd0, redirect}, 32'd1);
    idle();

`ifdef FETCH_IRQ_EN
    jr_en = 1; jr_target = 32'hC0;
    step(); cmp("jr_pc", pc, 32'hC0); cmp("jr_kernel", {31'd0, kernel}, 32'd0);
    idle(); jump_en = 1; jump_target = 32'h100;
    step(); cmp("jmp_pc", pc, 32'h100);
    idle(); irq = 1;
    step(); cmp("irq_pc", pc, 32'h4); cmp("irq_epc", epc, 32'h100);
    cmp("irq_kernel", {31'd0, kernel}, 32'd1);
    step(); cmp("irq_masked_pc", pc, 32'h8);
    irq = 0; jr_en = 1; jr_target = 32'h100;
    step(); cmp("eret_pc", pc, 32'h100); cmp("eret_kernel", {31'd0, kernel}, 32'd0);
    idle(); irq = 1;
`endif
    exc = 1; branch_en = 1; branch_target = 32'h300;
    step(); cmp("exc_pc", pc, 32'h8); cmp("exc_epc", epc, 32'h300);
    idle(); irq = 0;

    // PC+4 wraps
    jump_en = 1; jump_target = 32'hFFFF_FFFF;
    step(); cmp("wrap_jmp_pc", pc, 32'hFFFF_FFFC);
    idle();
    step(); cmp("wrap_pc", pc, 32'h0);

    // Random requests against the model
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      branch_en     = ($urandom_range(0, 9) == 0);
      jr_en         = ($urandom_range(0, 11) == 0);
      jump_en       = ($urandom_range(0, 9) == 0);
      exc           = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) irq = ~irq;
      branch_target = $urandom;
      jr_target     = $urandom;
      jump_target   = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
